// File: rtl/timer_sched.sv
// timer_sched: NREQ requesters share one timeout counter.
// A round-robin arbiter picks an owner in IDLE. The owner's length is latched
// and counted in RUN. Expiry gives a one-cycle done pulse through the DONE state.
// Dropping req or raising cancel while owning aborts the timeout without a done pulse.
module timer_sched #(
  parameter int NREQ  = 4,
  parameter int CNT_W = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*CNT_W-1:0] req_len,
  input  logic [NREQ-1:0]       cancel,
  output logic [NREQ-1:0]       grant,
  output logic [NREQ-1:0]       done,
  output logic                  busy
);

  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [NREQ-1:0] ONE_HOT0 = NREQ'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state, w_state_next;
  logic [NREQ-1:0]    r_grant, w_grant_next;
  logic [NREQ-1:0]    r_done, w_done_next;
  logic               r_busy;
  logic [CNT_W-1:0]   r_cnt, w_cnt_next;
  logic [CNT_W-1:0]   r_len_q, w_len_q_next;
  // Index of the most recent winner. It is also the owner index while in RUN.
  logic [IDX_W-1:0]   r_last, w_last_next;

  logic [NREQ-1:0]    w_elig;
  logic [CNT_W-1:0]   w_len_arr [NREQ];
  logic [IDX_W-1:0]   w_cand_idx [NREQ];
  logic [NREQ-1:0]    w_cand_ok;
  logic               w_win_found;
  logic [IDX_W-1:0]   w_win_idx;
  logic               w_abort;

  // A requester with cancel high is not eligible to win.
  assign w_elig = req & ~cancel;

  // Candidate gi is the requester at position gi+1 after the last winner.
  // Candidate 0 therefore has the highest priority.
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_cand
    logic [IDX_W:0] w_sum;
    assign w_len_arr[gi]  = req_len[gi*CNT_W +: CNT_W];
    assign w_sum          = {1'b0, r_last} + (IDX_W+1)'(gi + 1);
    assign w_cand_idx[gi] = (w_sum >= (IDX_W+1)'(NREQ)) ?
                            IDX_W'(w_sum - (IDX_W+1)'(NREQ)) : IDX_W'(w_sum);
    assign w_cand_ok[gi]  = w_elig[w_cand_idx[gi]];
  end

  // Priority pick over the rotated candidates. The scan runs downward so that
  // the lowest rotated position is written last and wins.
  always_comb begin
    w_win_found = 1'b0;
    w_win_idx   = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (w_cand_ok[k]) begin
        w_win_found = 1'b1;
        w_win_idx   = w_cand_idx[k];
      end
    end
  end

  // Abort is checked before expiry. If both happen in the same cycle, abort wins.
  assign w_abort = !req[r_last] || cancel[r_last];

  // Next-state and output decode. Defaults hold state and clear the done pulse.
  always_comb begin
    w_state_next = r_state;
    w_grant_next = r_grant;
    w_done_next  = '0;
    w_cnt_next   = r_cnt;
    w_len_q_next = r_len_q;
    w_last_next  = r_last;
    unique case (r_state)
      S_IDLE: begin
        w_grant_next = '0;
        if (w_win_found) begin
          w_state_next = S_RUN;
          w_grant_next = ONE_HOT0 << w_win_idx;
          w_len_q_next = w_len_arr[w_win_idx];
          w_cnt_next   = '0;
          w_last_next  = w_win_idx;
        end
      end
      S_RUN: begin
        if (w_abort) begin
          w_state_next = S_IDLE;
          w_grant_next = '0;
          w_cnt_next   = '0;
        end else if (r_cnt == r_len_q) begin
          w_state_next = S_DONE;
          w_grant_next = '0;
          w_done_next  = ONE_HOT0 << r_last;
        end else begin
          w_cnt_next   = r_cnt + CNT_W'(1);
        end
      end
      S_DONE: begin
        w_state_next = S_IDLE;
        w_grant_next = '0;
      end
      default: begin
        w_state_next = S_IDLE;
        w_grant_next = '0;
      end
    endcase
  end

  // State register. After reset, requester 0 is the first in line.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_grant <= '0;
      r_done  <= '0;
      r_busy  <= 1'b0;
      r_cnt   <= '0;
      r_len_q <= '0;
      r_last  <= IDX_W'(NREQ - 1);
    end else begin
      r_state <= w_state_next;
      r_grant <= w_grant_next;
      r_done  <= w_done_next;
      r_busy  <= (w_state_next != S_IDLE);
      r_cnt   <= w_cnt_next;
      r_len_q <= w_len_q_next;
      r_last  <= w_last_next;
    end
  end

  assign grant = r_grant;
  assign done  = r_done;
  assign busy  = r_busy;

endmodule

// File: tb/tb_timer_sched.sv
// Directed bench for timer_sched (NREQ=4, CNT_W=10).
// Outputs are sampled 1 time unit after each rising edge.
// Inputs are driven at that same point, so each one is sampled at the next edge.
module tb_timer_sched;

  localparam int NREQ  = 4;
  localparam int CNT_W = 10;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NREQ-1:0]       req;
  logic [NREQ*CNT_W-1:0] req_len;
  logic [NREQ-1:0]       cancel;
  logic [NREQ-1:0]       grant;
  logic [NREQ-1:0]       done;
  logic                  busy;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  timer_sched #(.NREQ(NREQ), .CNT_W(CNT_W)) dut (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .req_len(req_len),
    .cancel (cancel),
    .grant  (grant),
    .done   (done),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_len(input int i, input int v);
    req_len[i*CNT_W +: CNT_W] = CNT_W'(v);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic [3:0] g, input logic [3:0] d,
                            input logic b);
    chk({tag, ".grant"}, {28'd0, grant}, {28'd0, g});
    chk({tag, ".done"},  {28'd0, done},  {28'd0, d});
    chk({tag, ".busy"},  {31'd0, busy},  {31'd0, b});
    $display("step %s: grant=%b done=%b busy=%b", tag, grant, done, busy);
  endtask

  // Hard stop in case the sequence ever stalls.
  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0] oh;
    rst = 1'b1; req = '0; cancel = '0; req_len = '0;
    tick(); tick();
    expect_out("reset", 4'b0000, 4'b0000, 1'b0);
    rst = 1'b0;
    tick();
    expect_out("idle_after_reset", 4'b0000, 4'b0000, 1'b0);

    // Single request, len 5. The length changes after the latch and must be ignored.
    req = 4'b0010; set_len(1, 5);
    tick();                                   // T+1
    expect_out("single_t1", 4'b0010, 4'b0000, 1'b1);
    set_len(1, 1);
    for (int c = 2; c <= 6; c++) begin
      tick();
      expect_out($sformatf("single_t%0d", c), 4'b0010, 4'b0000, 1'b1);
    end
    tick();                                   // T+7
    expect_out("single_t7", 4'b0000, 4'b0010, 1'b1);
    req = 4'b0000;
    tick();
    expect_out("single_t8", 4'b0000, 4'b0000, 1'b0);

    // Zero length.
    req = 4'b0001; set_len(0, 0);
    tick();
    expect_out("zero_t1", 4'b0001, 4'b0000, 1'b1);
    tick();
    expect_out("zero_t2", 4'b0000, 4'b0001, 1'b1);
    req = 4'b0000;
    tick();
    expect_out("zero_t3", 4'b0000, 4'b0000, 1'b0);

    // Round robin with all lengths at 2. Reset first so requester 0 leads.
    rst = 1'b1; tick(); rst = 1'b0; tick();
    for (int i = 0; i < NREQ; i++) set_len(i, 2);
    req = 4'b1111;
    for (int r = 0; r < 5; r++) begin
      oh = 4'b0001 << (r % 4);
      tick();
      expect_out($sformatf("rr%0d_g0", r), oh, 4'b0000, 1'b1);
      tick();
      expect_out($sformatf("rr%0d_g1", r), oh, 4'b0000, 1'b1);
      tick();
      expect_out($sformatf("rr%0d_g2", r), oh, 4'b0000, 1'b1);
      tick();
      expect_out($sformatf("rr%0d_done", r), 4'b0000, oh, 1'b1);
      tick();
      expect_out($sformatf("rr%0d_idle", r), 4'b0000, 4'b0000, 1'b0);
    end
    req = 4'b0000;

    // Abort. The last winner is 0, so 2 beats 3. Requester 3 waits while 2 runs.
    set_len(2, 10); set_len(3, 3);
    req = 4'b1100;
    tick();                                   // cnt 0
    expect_out("abort_g0", 4'b0100, 4'b0000, 1'b1);
    for (int c = 1; c <= 4; c++) begin
      tick();
      expect_out($sformatf("abort_cnt%0d", c), 4'b0100, 4'b0000, 1'b1);
    end
    req = 4'b1000;                            // drop req[2] at cnt 4
    tick();
    expect_out("abort_idle", 4'b0000, 4'b0000, 1'b0);
    tick();
    expect_out("abort_next_grant", 4'b1000, 4'b0000, 1'b1);
    tick(); tick(); tick();
    expect_out("abort_next_run", 4'b1000, 4'b0000, 1'b1);
    tick();
    expect_out("abort_next_done", 4'b0000, 4'b1000, 1'b1);
    req = 4'b0000;
    tick();
    expect_out("abort_next_idle", 4'b0000, 4'b0000, 1'b0);

    // Cancel in the same cycle as expiry. The last winner is 3, so 0 wins.
    set_len(0, 3);
    req = 4'b0001;
    tick();
    expect_out("coll_g0", 4'b0001, 4'b0000, 1'b1);
    tick(); tick(); tick();                   // cnt == len_q
    expect_out("coll_cnt3", 4'b0001, 4'b0000, 1'b1);
    cancel = 4'b0001;
    tick();
    expect_out("coll_idle", 4'b0000, 4'b0000, 1'b0);
    cancel = 4'b0000; req = 4'b0000;
    tick();
    expect_out("coll_no_done", 4'b0000, 4'b0000, 1'b0);

    // Reset in the middle of a run. The last winner is 0, so 1 wins first.
    for (int i = 0; i < NREQ; i++) set_len(i, 8);
    req = 4'b1111;
    tick();
    expect_out("rstrun_g0", 4'b0010, 4'b0000, 1'b1);
    tick(); tick(); tick();                   // cnt 3
    rst = 1'b1;
    tick();
    expect_out("rstrun_reset", 4'b0000, 4'b0000, 1'b0);
    rst = 1'b0;
    tick();
    expect_out("rstrun_regrant", 4'b0001, 4'b0000, 1'b1);
    req = 4'b0000;
    tick();
    expect_out("rstrun_abort", 4'b0000, 4'b0000, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/timer_sched.md
TIMER_SCHED -- requirements
Module: timer_sched

Interface
REQ-001 The block SHALL take parameter NREQ, default 4, as the number of requesters sharing one timeout counter (range 2..8).
REQ-002 The block SHALL take parameter CNT_W, default 10, as the counter and length width in bits.
REQ-003 Port clk  input  1  single clock; all logic on its rising edge.
REQ-004 Port rst  input  1  reset; synchronous, active-high.
REQ-005 Port req  input  NREQ  per-requester timeout request; level, held until done or abort.
REQ-006 Port req_len  input  NREQ*CNT_W  per-requester timeout length; slice i is bits [i*CNT_W +: CNT_W].
REQ-007 Port cancel  input  NREQ  per-requester abort; level.
REQ-008 Port grant  output  NREQ  one-hot, registered; marks the current counter owner.
REQ-009 Port done  output  NREQ  one-hot, registered, one-cycle pulse; marks timeout expiry for the owner.
REQ-010 Port busy  output  1  registered; high in every state other than IDLE.

Function
REQ-011 The FSM SHALL have states IDLE, RUN and DONE.
REQ-012 In IDLE, when any req[i] is high and cancel[i] is low, the block SHALL choose a winner round-robin, starting the search at index (last_winner+1) mod NREQ.
REQ-013 The arbitration SHALL skip any requester whose cancel is high.
REQ-014 On a win, the block SHALL, on the next edge, set grant to the winner's one-hot, latch req_len[winner] into len_q, clear cnt to 0, update last_winner, and enter RUN.
REQ-015 req_len changes after the latch SHALL have no effect on the running timeout.
REQ-016 In RUN with cnt != len_q, the block SHALL increment cnt by 1; cnt SHALL never wrap, because len_q <= 2^CNT_W-1 bounds it.
REQ-017 In RUN with cnt == len_q, the block SHALL on the next edge clear grant, pulse done[owner] for exactly one cycle, and enter DONE.
REQ-018 Timing: with req sampled in IDLE at cycle T, grant SHALL be high from T+1 through T+len+1, and done SHALL be high at T+len+2.
REQ-019 For len = 0, the block SHALL assert grant for one cycle (T+1) and done at T+2.
REQ-020 From DONE, the block SHALL return to IDLE unconditionally after one cycle; no arbitration occurs in DONE.
REQ-021 Requesters SHALL drop req on seeing done; a req still high in IDLE is treated as a new request.
REQ-022 Abort: in RUN, if req[owner] goes low or cancel[owner] goes high, the block SHALL on the next edge clear grant, reset cnt to 0, and enter IDLE with no done pulse.
REQ-023 On an abort, last_winner SHALL still advance to the aborted owner.
REQ-024 Abort SHALL take priority over expiry when both occur in the same cycle.
REQ-025 req or cancel activity from non-owners during RUN or DONE SHALL be ignored until IDLE.
REQ-026 With at most one hot bit in grant and done, done and grant SHALL never be high in the same cycle.

Reset
REQ-027 While rst is high, the block SHALL drive state=IDLE, grant=0, done=0, busy=0, cnt=0, len_q=0, and last_winner=NREQ-1, so that requester 0 has first priority.
REQ-028 Reset asserted mid-RUN SHALL abort the timeout with no done pulse, and the block SHALL be in IDLE on the first cycle after rst falls.
REQ-029 Reset SHALL override all other inputs in the same cycle.

Verification
REQ-030 Single request: req=4'b0010, req_len[1]=5 at T -> grant=4'b0010 for T+1..T+6, done=4'b0010 at T+7, busy high T+1..T+7.
REQ-031 Zero length: req=4'b0001, len 0 -> grant=4'b0001 at T+1 only, done=4'b0001 at T+2.
REQ-032 Round-robin: req=4'b1111 held and re-asserted after each done, all len 2 -> grant order 0,1,2,3,0 with done every 5 cycles.
REQ-033 Abort: req[2] len 10, drop req[2] at cnt=4 -> grant cleared next cycle, no done, state IDLE; a pending req[3] is granted one cycle later.
REQ-034 Cancel versus expiry collision: cancel[owner] rises in the cycle cnt==len_q -> no done pulse, state returns to IDLE.
REQ-035 Reset mid-run: rst pulsed at cnt=3 of a len 8 timeout -> grant=0, done=0, busy=0 next cycle; the next winner is requester 0 when all req are high.
